// File: rtl/max_pool_stream.sv
// Streaming PoolN x PoolN max-pool (stride PoolN) over a raster pixel stream, all channels in parallel.
// Per-channel partial maxima of the current window row are kept in a line buffer of ImageWidth/PoolN entries.
module max_pool_stream #(
  parameter int BitSize     = 8,
  parameter int Channels    = 4,
  parameter int ImageWidth  = 28,
  parameter int ImageHeight = 28,
  parameter int PoolN       = 2,
  parameter int ZeroFloor   = 1
) (
  input  logic                        clk,
  input  logic                        res_n,
  input  logic                        clear,
  input  logic                        in_valid,
  input  logic [Channels*BitSize-1:0] in_data,
  output logic                        out_valid,
  output logic [Channels*BitSize-1:0] out_data,
  output logic                        frame_done
);

  localparam int BlkW    = ImageWidth / PoolN;
  localparam int BlkH    = ImageHeight / PoolN;
  localparam int ColW    = $clog2(ImageWidth + 1);
  localparam int RowW    = $clog2(ImageHeight + 1);
  localparam int WinW    = $clog2(PoolN + 1);
  localparam int LbW     = $clog2(BlkW + 1);
  localparam int LbDepth = 1 << LbW;

  function automatic logic signed [BitSize-1:0] max_s(input logic signed [BitSize-1:0] a,
                                                      input logic signed [BitSize-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // A zero seed folds a ReLU into the pooling.
  function automatic logic signed [BitSize-1:0] seed_val();
    if (ZeroFloor != 0) return '0;
    return {1'b1, {(BitSize-1){1'b0}}};
  endfunction

  logic [ColW-1:0] col;
  logic [RowW-1:0] row;
  logic [WinW-1:0] wc;
  logic [WinW-1:0] wr;
  logic [LbW-1:0]  blk;

  logic signed [BitSize-1:0] acc [Channels];
  logic signed [BitSize-1:0] lb  [LbDepth][Channels];

  logic                      accept_p0;
  logic                      col_last_p0;
  logic                      row_last_p0;
  logic                      wc_last_p0;
  logic                      wr_last_p0;
  logic                      wr_first_p0;
  logic                      live_p0;
  logic                      emit_p0;
  logic                      lb_wr_p0;
  logic signed [BitSize-1:0] px_p0       [Channels];
  logic signed [BitSize-1:0] acc_next_p0 [Channels];
  logic signed [BitSize-1:0] lb_merge_p0 [Channels];

  logic                        vld_p1;
  logic                        done_p1;
  logic [Channels*BitSize-1:0] data_p1;

  // ---- stage p0: incoming beat, window position and per-channel maxima
  always_comb begin
    accept_p0   = in_valid && !clear;
    col_last_p0 = (col == ColW'(ImageWidth - 1));
    row_last_p0 = (row == RowW'(ImageHeight - 1));
    wc_last_p0  = (wc == WinW'(PoolN - 1));
    wr_last_p0  = (wr == WinW'(PoolN - 1));
    wr_first_p0 = (wr == '0);
    // Trailing columns/rows that do not fill a whole window are counted but ignored.
    live_p0     = (col < ColW'(BlkW * PoolN)) && (row < RowW'(BlkH * PoolN));
    emit_p0     = accept_p0 && live_p0 && wc_last_p0 && wr_last_p0;
    lb_wr_p0    = accept_p0 && live_p0 && wc_last_p0 && !wr_last_p0;
    for (int c = 0; c < Channels; c++) begin
      px_p0[c]       = in_data[c*BitSize +: BitSize];
      acc_next_p0[c] = max_s((wc == '0) ? seed_val() : acc[c], px_p0[c]);
      lb_merge_p0[c] = max_s(lb[blk][c], acc_next_p0[c]);
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      col     <= '0;
      row     <= '0;
      wc      <= '0;
      wr      <= '0;
      blk     <= '0;
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
    end else begin
      vld_p1  <= emit_p0;
      done_p1 <= accept_p0 && col_last_p0 && row_last_p0;
      if (clear) begin
        col <= '0;
        row <= '0;
        wc  <= '0;
        wr  <= '0;
        blk <= '0;
      end else if (in_valid) begin
        if (col_last_p0) begin
          col <= '0;
          wc  <= '0;
          blk <= '0;
          if (row_last_p0) begin
            row <= '0;
            wr  <= '0;
          end else begin
            row <= row + 1'b1;
            wr  <= wr_last_p0 ? '0 : wr + 1'b1;
          end
        end else begin
          col <= col + 1'b1;
          if (wc_last_p0) begin
            wc  <= '0;
            blk <= blk + 1'b1;
          end else begin
            wc <= wc + 1'b1;
          end
        end
      end
    end
  end

  // ---- stage p1: registered pooled pixel; line buffer and accumulators update alongside
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      data_p1 <= '0;
      for (int c = 0; c < Channels; c++) acc[c] <= '0;
      for (int e = 0; e < LbDepth; e++) begin
        for (int c = 0; c < Channels; c++) lb[e][c] <= '0;
      end
    end else begin
      if (emit_p0) begin
        for (int c = 0; c < Channels; c++) data_p1[c*BitSize +: BitSize] <= lb_merge_p0[c];
      end
      if (clear) begin
        for (int c = 0; c < Channels; c++) acc[c] <= '0;
      end else if (in_valid) begin
        for (int c = 0; c < Channels; c++) acc[c] <= acc_next_p0[c];
      end
      // The first window row overwrites stale entries, so lb never needs an explicit clear.
      if (lb_wr_p0) begin
        for (int c = 0; c < Channels; c++) lb[blk][c] <= wr_first_p0 ? acc_next_p0[c] : lb_merge_p0[c];
      end
    end
  end

  assign out_valid  = vld_p1;
  assign out_data   = data_p1;
  assign frame_done = done_p1;

endmodule
